sram_loader: RTL
================

Name: sram_loader

Overview:
- Sequencer directly upstream of the 64 KB SRAM. It writes a byte stream (from the SPI/flash reader) into SRAM at consecutive addresses starting from a programmable base.
- After the load, it hands the SRAM port over to the host CPU bus.
- It owns the SRAM address, datain, CS and WE lines and guarantees clean write strobes: address and data are stable before and after WE.

Parameters:
- ADDR_W, 16, SRAM address width.
- DATA_W, 8, data width.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- load_start  in  1  single-cycle request to begin a load; sampled only when not busy.
- load_base  in  16  first SRAM address; captured with load_start.
- load_len  in  17  byte count, 0..65536; captured with load_start.
- in_data  in  8  stream byte.
- in_valid  in  1  stream byte valid.
- in_ready  out  1  loader accepts byte this cycle.
- load_busy  out  1  high from the cycle after an accepted load_start until DONE.
- load_done  out  1  sticky; set on completion, cleared by the next accepted load_start or by rst.
- cpu_addr  in  16  host bus address.
- cpu_din  in  8  host write data.
- cpu_cs  in  1  host chip select.
- cpu_we  in  1  host write enable.
- cpu_dout  out  8  host read data.
- sram_address  out  16  to SRAM address.
- sram_datain  out  8  to SRAM datain.
- sram_cs  out  1  to SRAM CS.
- sram_we  out  1  to SRAM WE.
- sram_dataout  in  8  from SRAM dataout.

Behaviour:
- States: IDLE, FETCH, SETUP, STROBE, HOLD, DONE. DONE behaves like IDLE for bus ownership.
- Reset values: state IDLE, in_ready 0, load_busy 0, load_done 0, internal address/count/data registers 0.
- IDLE/DONE (pass-through):
  - sram_address=cpu_addr, sram_datain=cpu_din, sram_cs=cpu_cs, sram_we=cpu_we, cpu_dout=sram_dataout. All combinational, zero latency.
  - With rst high, sram_cs and sram_we are forced 0 regardless of the cpu inputs.
- Start: in IDLE/DONE, load_start=1 captures base into addr_q and len into cnt_q, and clears load_done.
  - If len=0: go to DONE next cycle and set load_done; no SRAM write occurs.
  - Otherwise go to FETCH.
  - load_start in any other state is ignored.
- FETCH: in_ready=1, sram_cs=0, sram_we=0. On in_valid & in_ready, latch in_data into data_q and go to SETUP. With no valid byte, stay in FETCH indefinitely.
- SETUP: sram_address=addr_q, sram_datain=data_q, sram_cs=1, sram_we=0.
- STROBE: same address/data, sram_cs=1, sram_we=1 (exactly one cycle).
- HOLD: same address/data, sram_cs=1, sram_we=0. On exit: addr_q += 1 (16-bit wrap, 0xFFFF -> 0x0000) and cnt_q -= 1. If the new cnt_q is 0, go to DONE and set load_done; else go to FETCH.
- Throughput: 4 cycles per byte with in_valid held high (FETCH, SETUP, STROBE, HOLD).
- During FETCH..HOLD, cpu_* inputs are ignored and cpu_dout=8'hFF. Host accesses are dropped, not queued.
- in_ready is high only in FETCH. A byte is never accepted in any other state.
- load_len=65536 writes every location exactly once, wrapping through 0xFFFF when base≠0.
- Reset asserted mid-load: immediate return to IDLE and SRAM strobes deasserted asynchronously. No partial write completes after rst. load_done stays 0.

Test Plan:
- Reset then pass-through: cpu_addr=0x1234, cpu_din=0x5A, cpu_cs=1, cpu_we=1 for one cycle, then read 0x1234 -> cpu_dout=0x5A; load_busy=0, load_done=0.
- Load of 4 bytes: base=0xC000, len=4, stream 0xA9,0x01,0x8D,0x00 with in_valid held -> sram_we pulses at 0xC000..0xC003, each preceded and followed by a cycle with the same address; load_done set 16 cycles after the first FETCH; readback matches.
- Wrap: base=0xFFFE, len=4, bytes 0x11..0x44 -> 0xFFFE=0x11, 0xFFFF=0x22, 0x0000=0x33, 0x0001=0x44.
- Stall: in_valid toggling 1,0,0,1 -> in_ready stays high while waiting, no extra sram_we pulses; total writes equal len.
- Edge commands: len=0 -> load_done=1 next cycle with no sram_cs. load_start during a load is ignored. A CPU write during a load leaves the SRAM unchanged and cpu_dout=0xFF.
- rst asserted in STROBE -> sram_we=0 in the same cycle, state IDLE, load_done=0; a subsequent load completes normally.

Source files
------------

// File: rtl/sram_loader.sv
// Loads a byte stream into SRAM at consecutive addresses, then hands the SRAM port to the host bus.
// Each byte uses four cycles (FETCH/SETUP/STROBE/HOLD) so address and data bracket the WE pulse.
module sram_loader #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_base,
    input  logic [ADDR_W:0]   load_len,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              load_busy,
    output logic              load_done,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_din,
    input  logic              cpu_cs,
    input  logic              cpu_we,
    output logic [DATA_W-1:0] cpu_dout,
    output logic [ADDR_W-1:0] sram_address,
    output logic [DATA_W-1:0] sram_datain,
    output logic              sram_cs,
    output logic              sram_we,
    input  logic [DATA_W-1:0] sram_dataout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_DONE
    } state_t;

    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_cnt;
    logic [DATA_W-1:0] r_data;
    logic              r_done;
    logic              w_idle;
    logic              w_start;
    logic              w_len_zero;

    assign w_idle     = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_start    = w_idle && load_start;
    assign w_len_zero = (load_len == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        in_ready     = 1'b0;
        load_busy    = 1'b1;
        sram_address = r_addr;
        sram_datain  = r_data;
        sram_cs      = 1'b0;
        sram_we      = 1'b0;
        cpu_dout     = '1;
        case (r_state)
            S_IDLE, S_DONE: begin
                load_busy    = 1'b0;
                // Host owns the SRAM; reset must still suppress any strobe.
                sram_address = cpu_addr;
                sram_datain  = cpu_din;
                sram_cs      = cpu_cs & ~rst;
                sram_we      = cpu_we & ~rst;
                cpu_dout     = sram_dataout;
                if (load_start) w_next = w_len_zero ? S_DONE : S_FETCH;
            end
            S_FETCH: begin
                in_ready = 1'b1;
                if (in_valid) w_next = S_SETUP;
            end
            S_SETUP: begin
                sram_cs = 1'b1;
                w_next  = S_STROBE;
            end
            S_STROBE: begin
                sram_cs = 1'b1;
                sram_we = 1'b1;
                w_next  = S_HOLD;
            end
            S_HOLD: begin
                sram_cs = 1'b1;
                w_next  = (r_cnt == CNT_ONE) ? S_DONE : S_FETCH;
            end
            default: begin
                load_busy = 1'b0;
                w_next    = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= '0;
            r_cnt  <= '0;
            r_data <= '0;
            r_done <= 1'b0;
        end else begin
            if (w_start) begin
                r_addr <= load_base;
                r_cnt  <= load_len;
                r_done <= w_len_zero;
            end
            if (r_state == S_FETCH && in_valid) r_data <= in_data;
            if (r_state == S_HOLD) begin
                r_addr <= r_addr + ADDR_ONE;
                r_cnt  <= r_cnt - CNT_ONE;
                if (r_cnt == CNT_ONE) r_done <= 1'b1;
            end
        end
    end

    assign load_done = r_done;

endmodule
